// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared state encoding and constants for the LED arbiter
package led_pkg;

  typedef enum logic [1:0] {
    S_PS    = 2'd0,
    S_HOLD  = 2'd1,
    S_ALARM = 2'd2
  } led_state_t;

  localparam logic [7:0] LED_IDLE_PAT = 8'h87;
  localparam logic [7:0] LED_ALL_ON   = 8'hFF;
  localparam logic [7:0] LED_ALL_OFF  = 8'h00;

  // PS value when software is driving, otherwise the idle pattern
  function automatic logic [7:0] ps_view(input logic [7:0] ps_led, input logic [7:0] idle_pat);
    return (ps_led != 8'h00) ? ps_led : idle_pat;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - free-running display tick divider
module led_tick_gen #(
  parameter int P_TICK_DIV = 12500000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int CW = (P_TICK_DIV > 2) ? $clog2(P_TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(P_TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // count 0..P_TICK_DIV-1, flag one cycle whenever the counter wraps to 0
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt    <= '0;
      o_tick <= 1'b1;
    end else begin
      cnt    <= cnt + 1'b1;
      o_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/led_arbiter.sv
// rtl/led_arbiter.sv - LED ownership arbiter: alarm over timed pattern over PS software
module led_arbiter
  import led_pkg::*;
#(
  parameter int         P_TICK_DIV = 12500000,
  parameter logic [7:0] P_IDLE_PAT = LED_IDLE_PAT
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_PS_LED,
  input  logic       i_alarm,
  input  logic       i_req_valid,
  input  logic [7:0] i_req_pattern,
  input  logic [7:0] i_req_ticks,
  output logic       o_req_ack,
  output logic       o_busy,
  output logic [7:0] o_LED
);

  led_state_t state;
  logic       tick;
  logic [7:0] led_q;
  logic       ack_q;
  logic       busy_q;
  logic [7:0] hold_pat;
  logic [7:0] hold_remain;

  // The divider runs independently of the FSM, so a hold's first tick can come early
  led_tick_gen #(
    .P_TICK_DIV(P_TICK_DIV)
  ) u_tick_gen (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .o_tick (tick)
  );

  // Ownership FSM; every output is a flop updated alongside the state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_PS;
      led_q       <= LED_ALL_OFF;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      hold_pat    <= 8'h00;
      hold_remain <= 8'h00;
    end else begin
      ack_q <= 1'b0;
      if (i_alarm) begin
        // alarm wins from any state and silently aborts a running hold
        state  <= S_ALARM;
        busy_q <= 1'b0;
        if (state != S_ALARM) begin
          led_q <= LED_ALL_ON;
        end else if (tick) begin
          led_q <= ~led_q;
        end
      end else begin
        case (state)
          S_PS: begin
            // ack_q guard keeps the acknowledge a strict single-cycle pulse
            if (i_req_valid && !ack_q) begin
              hold_pat    <= i_req_pattern;
              hold_remain <= (i_req_ticks == 8'd0) ? 8'd1 : i_req_ticks;
              ack_q       <= 1'b1;
              busy_q      <= 1'b1;
              led_q       <= i_req_pattern;
              state       <= S_HOLD;
            end else begin
              led_q <= ps_view(i_PS_LED, P_IDLE_PAT);
            end
          end
          S_HOLD: begin
            led_q <= hold_pat;
            if (tick) begin
              if (hold_remain <= 8'd1) begin
                state  <= S_PS;
                busy_q <= 1'b0;
                led_q  <= ps_view(i_PS_LED, P_IDLE_PAT);
              end else begin
                hold_remain <= hold_remain - 8'd1;
              end
            end
          end
          S_ALARM: begin
            state <= S_PS;
            led_q <= ps_view(i_PS_LED, P_IDLE_PAT);
          end
          default: begin
            state  <= S_PS;
            busy_q <= 1'b0;
            led_q  <= ps_view(i_PS_LED, P_IDLE_PAT);
          end
        endcase
      end
    end
  end

  assign o_LED     = led_q;
  assign o_req_ack = ack_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_led_arbiter.sv
// tb/tb_led_arbiter.sv - scoreboard bench for led_arbiter with a 4-cycle tick
module tb_led_arbiter;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [7:0] i_PS_LED = 8'h00;
  logic       i_alarm = 1'b0;
  logic       i_req_valid = 1'b0;
  logic [7:0] i_req_pattern = 8'h00;
  logic [7:0] i_req_ticks = 8'h00;
  logic       o_req_ack;
  logic       o_busy;
  logic [7:0] o_LED;

  always #5 i_clk = ~i_clk;

  led_arbiter #(
    .P_TICK_DIV(4),
    .P_IDLE_PAT(8'h87)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_PS_LED     (i_PS_LED),
    .i_alarm      (i_alarm),
    .i_req_valid  (i_req_valid),
    .i_req_pattern(i_req_pattern),
    .i_req_ticks  (i_req_ticks),
    .o_req_ack    (o_req_ack),
    .o_busy       (o_busy),
    .o_LED        (o_LED)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_led_q[$];
  int         exp_ack_q[$];
  int         n_changes = 0;
  logic [7:0] prev_led = 8'h00;
  logic       prev_ack = 1'b0;
  logic [7:0] mon_exp;
  int         mon_tok;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: every LED change pops the next expected value; every ack pops an expected ack
  always @(negedge i_clk) begin
    if (o_LED !== prev_led) begin
      if (exp_led_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL led_unexpected actual=%0h expected=none", o_LED);
      end else begin
        mon_exp = exp_led_q.pop_front();
        check("led_seq", {24'h0, o_LED}, {24'h0, mon_exp});
      end
      prev_led = o_LED;
      n_changes++;
    end
    if (o_req_ack) begin
      if (exp_ack_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ack_unexpected actual=1 expected=0");
      end else begin
        mon_tok = exp_ack_q.pop_front();
        check("ack_with_busy", {31'h0, o_busy}, 32'd1);
      end
      check("ack_not_double", {31'h0, prev_ack}, 32'd0);
    end
    prev_ack = o_req_ack;
  end

  // step to just after the next falling edge, after the monitor has sampled
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge i_clk);
      #1;
    end
  endtask

  task automatic wait_changes(input int target, input string name);
    int budget;
    budget = 100;
    while (n_changes < target && budget > 0) begin
      cyc(1);
      budget--;
    end
    check(name, {31'h0, (n_changes >= target)}, 32'd1);
  endtask

  task automatic do_req(input logic [7:0] pat, input logic [7:0] ticks, output int busy_cycles);
    exp_ack_q.push_back(1);
    i_req_pattern = pat;
    i_req_ticks   = ticks;
    i_req_valid   = 1'b1;
    cyc(1);
    check("ack_latency", {31'h0, o_req_ack}, 32'd1);
    i_req_valid = 1'b0;
    busy_cycles = 0;
    while (o_busy && busy_cycles < 200) begin
      busy_cycles++;
      cyc(1);
    end
  endtask

  initial begin
    int bc;
    int n_bad;
    int budget;
    int gap;

    // reset state
    cyc(2);
    check("reset_led", {24'h0, o_LED}, 32'h00);
    check("reset_busy", {31'h0, o_busy}, 32'd0);
    check("reset_ack", {31'h0, o_req_ack}, 32'd0);

    // idle pattern from the first edge, then PS value one cycle after it changes
    exp_led_q.push_back(8'h87);
    i_rst_n = 1'b1;
    cyc(1);
    check("idle_after_reset", {24'h0, o_LED}, 32'h87);
    exp_led_q.push_back(8'h3C);
    i_PS_LED = 8'h3C;
    cyc(1);
    check("ps_follow", {24'h0, o_LED}, 32'h3C);
    cyc(2);

    // timed request of 3 ticks: 9..12 busy cycles because the first tick can be early
    exp_led_q.push_back(8'hA5);
    exp_led_q.push_back(8'h3C);
    do_req(8'hA5, 8'd3, bc);
    check_range("hold3_len", bc, 9, 12);
    check("after_hold_led", {24'h0, o_LED}, 32'h3C);
    cyc(2);

    // ticks=0 acts as a single tick
    exp_led_q.push_back(8'h5A);
    exp_led_q.push_back(8'h3C);
    do_req(8'h5A, 8'd0, bc);
    check_range("hold0_len", bc, 1, 4);
    cyc(2);

    // valid held through a hold is not acked until the hold finishes
    exp_led_q.push_back(8'hC3);
    exp_led_q.push_back(8'h3C);
    exp_led_q.push_back(8'h11);
    exp_led_q.push_back(8'h3C);
    exp_ack_q.push_back(1);
    exp_ack_q.push_back(1);
    i_req_pattern = 8'hC3;
    i_req_ticks   = 8'd4;
    i_req_valid   = 1'b1;
    cyc(1);
    check("first_ack", {31'h0, o_req_ack}, 32'd1);
    i_req_pattern = 8'h11;
    i_req_ticks   = 8'd1;
    n_bad  = 0;
    budget = 100;
    do begin
      cyc(1);
      budget--;
      if (o_busy && o_req_ack) n_bad++;
    end while (o_busy && budget > 0);
    check("no_ack_in_hold", n_bad, 0);
    check("hold_gap_led", {24'h0, o_LED}, 32'h3C);
    cyc(1);
    check("second_ack", {31'h0, o_req_ack}, 32'd1);
    i_req_valid = 1'b0;
    budget = 100;
    while (o_busy && budget > 0) begin
      cyc(1);
      budget--;
    end
    check("second_hold_done", {31'h0, o_busy}, 32'd0);
    cyc(2);

    // alarm mid-hold aborts it, then the LEDs blink once per tick
    exp_led_q.push_back(8'hA5);
    exp_led_q.push_back(8'hFF);
    exp_led_q.push_back(8'h00);
    exp_led_q.push_back(8'hFF);
    exp_led_q.push_back(8'h3C);
    exp_ack_q.push_back(1);
    i_req_pattern = 8'hA5;
    i_req_ticks   = 8'd8;
    i_req_valid   = 1'b1;
    cyc(1);
    check("alarm_req_ack", {31'h0, o_req_ack}, 32'd1);
    i_req_valid = 1'b0;
    cyc(3);
    i_alarm = 1'b1;
    cyc(1);
    check("alarm_busy_drop", {31'h0, o_busy}, 32'd0);
    check("alarm_entry_led", {24'h0, o_LED}, 32'hFF);
    wait_changes(n_changes + 1, "alarm_first_toggle");
    gap = 0;
    budget = n_changes + 1;
    while (n_changes < budget && gap < 50) begin
      cyc(1);
      gap++;
    end
    check("alarm_toggle_period", gap, 4);
    i_alarm = 1'b0;
    cyc(1);
    check("alarm_exit_led", {24'h0, o_LED}, 32'h3C);
    check("alarm_exit_busy", {31'h0, o_busy}, 32'd0);
    cyc(2);

    // simultaneous alarm and request: alarm wins, no ack
    exp_led_q.push_back(8'hFF);
    exp_led_q.push_back(8'h00);
    exp_led_q.push_back(8'h3C);
    i_req_pattern = 8'h99;
    i_req_ticks   = 8'd2;
    i_req_valid   = 1'b1;
    i_alarm       = 1'b1;
    cyc(1);
    check("simul_no_ack", {31'h0, o_req_ack}, 32'd0);
    check("simul_led", {24'h0, o_LED}, 32'hFF);
    wait_changes(n_changes + 1, "simul_toggle");
    i_alarm     = 1'b0;
    i_req_valid = 1'b0;
    cyc(1);
    check("simul_exit_led", {24'h0, o_LED}, 32'h3C);
    cyc(2);

    // asynchronous reset during a hold
    exp_led_q.push_back(8'h77);
    exp_led_q.push_back(8'h00);
    exp_led_q.push_back(8'h3C);
    exp_ack_q.push_back(1);
    i_req_pattern = 8'h77;
    i_req_ticks   = 8'd8;
    i_req_valid   = 1'b1;
    cyc(1);
    check("rst_req_ack", {31'h0, o_req_ack}, 32'd1);
    i_req_valid = 1'b0;
    cyc(2);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("async_rst_led", {24'h0, o_LED}, 32'h00);
    check("async_rst_busy", {31'h0, o_busy}, 32'd0);
    cyc(2);
    i_rst_n = 1'b1;
    cyc(1);
    check("post_rst_led", {24'h0, o_LED}, 32'h3C);
    check("post_rst_busy", {31'h0, o_busy}, 32'd0);
    cyc(5);

    check("led_queue_drained", exp_led_q.size(), 0);
    check("ack_queue_drained", exp_ack_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
